vga_fb_scaled: RTL and testbench

- Parametrised VGA scan-out engine with double-buffered, pixel-replicated framebuffer storage.
- Generalises the single-buffer 640x480 12-bit controller in four ways: configurable colour depth, integer 2^S upscaling, configurable sync polarity, and vsync-synchronised front/back buffer swap for tear-free rendering.
- Sits between the pixel-producing logic (CPU/blitter) and the VGA DAC pins, in the 25 MHz pixel domain.

---
 rtl/vga_fb_scaled.sv | 161 ++++++++++++++++
 tb/tb_vga_fb_scaled.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scaled.sv
// VGA scan-out engine with a double-buffered, 2^S pixel-replicated framebuffer.
// Two-stage output pipeline: address/sync decode, then RAM read into output regs.
module vga_fb_scaled #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int COLOR_BITS  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       write_addr,
  input  logic [3*COLOR_BITS-1:0] write_data,
  input  logic                    swap_req,
  output logic                    swap_pending,
  output logic                    front_buf,
  output logic                    frame_start,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_de
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FB_W      = H_VISIBLE >> SCALE_SHIFT;
  localparam int FB_H      = V_VISIBLE >> SCALE_SHIFT;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int PA        = $clog2(FB_PIXELS);
  localparam int MEM_DEPTH = 2 ** (PA + 1);
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int DW        = 3 * COLOR_BITS;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SWAP  = VW'(V_VISIBLE - 1);
  localparam logic [HW:0]   H_VIS   = (HW+1)'(H_VISIBLE);
  localparam logic [VW:0]   V_VIS   = (VW+1)'(V_VISIBLE);
  localparam logic [HW:0]   HS_BEG  = (HW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [HW:0]   HS_END  = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW:0]   VS_BEG  = (VW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [VW:0]   VS_END  = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_PIXELS);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          swap_point;
  logic          vis0;
  logic          hs0;
  logic          vs0;
  logic          sof0;
  logic [PA-1:0] pix0;
  logic [PA:0]   rd_addr0;

  logic [PA:0]   rd_addr1;
  logic          vis1;
  logic          hs1;
  logic          vs1;

  logic          wr_ok;
  logic [PA:0]   wr_addr;
  logic [DW-1:0] rgb_q;
  logic [DW-1:0] mem [0:MEM_DEPTH-1];

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign swap_point = h_last && (v_cnt == V_SWAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // A request on the swap-point cycle is consumed directly and never pends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_point && (swap_pending || swap_req)) begin
      front_buf    <= ~front_buf;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  assign vis0 = ({1'b0, h_cnt} < H_VIS) && ({1'b0, v_cnt} < V_VIS);
  assign hs0  = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
  assign vs0  = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
  assign sof0 = (h_cnt == '0) && (v_cnt == '0);

  assign pix0 = PA'(v_cnt >> SCALE_SHIFT) * PA'(FB_W)
              + PA'(h_cnt >> SCALE_SHIFT);
  assign rd_addr0 = {front_buf, pix0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr1    <= '0;
      vis1        <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rd_addr1    <= rd_addr0;
      vis1        <= vis0;
      hs1         <= hs0;
      vs1         <= vs0;
      frame_start <= sof0;
    end
  end

  // Out-of-range addresses are dropped rather than truncated into range.
  assign wr_ok   = we && ({1'b0, write_addr} < FB_LIM);
  assign wr_addr = {~front_buf, write_addr[PA-1:0]};

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q     <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
    end else begin
      rgb_q     <= vis1 ? mem[rd_addr1] : '0;
      vga_de    <= vis1;
      vga_hsync <= hs1 ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync <= vs1 ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign vga_r = rgb_q[DW-1 -: COLOR_BITS];
  assign vga_g = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_b = rgb_q[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_fb_scaled.sv
// Bench for vga_fb_scaled on a shrunken 24x12 raster with a 8x4 framebuffer.
// A cycle model feeds an output scoreboard; scenario tasks add targeted checks.
module tb_vga_fb_scaled;

  localparam int H_VISIBLE = 16;
  localparam int H_FRONT   = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BACK    = 2;
  localparam int V_VISIBLE = 8;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 1;
  localparam int H_TOTAL   = 24;
  localparam int V_TOTAL   = 12;
  localparam int FRAME     = H_TOTAL * V_TOTAL;
  localparam int FB_W      = 8;
  localparam int FB_PIXELS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [5:0]  write_addr = '0;
  logic [11:0] write_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        front_buf;
  logic        frame_start;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;

  vga_fb_scaled #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .COLOR_BITS(4), .SCALE_SHIFT(1), .ADDR_W(6),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .we(we),
    .write_addr(write_addr), .write_data(write_data),
    .swap_req(swap_req), .swap_pending(swap_pending),
    .front_buf(front_buf), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_print = 0;

  int          mh = 0;
  int          mv = 0;
  bit          mfront = 1'b0;
  bit          mpend = 1'b0;
  bit          mfs = 1'b0;
  logic [11:0] mmem [2][32];
  bit          mvalid [2][32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0;
      mv <= 0;
      mfront <= 1'b0;
      mpend <= 1'b0;
      mfs <= 1'b0;
    end else begin
      if (we && write_addr < FB_PIXELS) begin
        mmem[~mfront][write_addr[4:0]] <= write_data;
        mvalid[~mfront][write_addr[4:0]] <= 1'b1;
      end
      mfs <= (mh == 0 && mv == 0);
      if (mh == H_TOTAL-1 && mv == V_VISIBLE-1 && (mpend || swap_req)) begin
        mfront <= ~mfront;
        mpend <= 1'b0;
      end else if (swap_req) begin
        mpend <= 1'b1;
      end
      if (mh == H_TOTAL-1) begin
        mh <= 0;
        mv <= (mv == V_TOTAL-1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        chk;
  } exp_t;

  localparam exp_t RST_E = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, de: 1'b0, chk: 1'b1};

  exp_t q[$];
  bit   primed = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    int   a;
    bit   vis;
    if (rst) begin
      q.delete();
      primed = 1'b0;
    end else begin
      if (!primed) begin
        q.push_back(RST_E);
        q.push_back(RST_E);
        primed = 1'b1;
      end
      vis = (mh < H_VISIBLE) && (mv < V_VISIBLE);
      if (vis) begin
        a = (mv >> 1) * FB_W + (mh >> 1);
        e.rgb = mmem[mfront][a];
        e.chk = mvalid[mfront][a];
      end else begin
        e.rgb = 12'h000;
        e.chk = 1'b1;
      end
      e.de = vis;
      e.hs = !(mh >= H_VISIBLE+H_FRONT && mh < H_VISIBLE+H_FRONT+H_SYNC);
      e.vs = !(mv >= V_VISIBLE+V_FRONT && mv < V_VISIBLE+V_FRONT+V_SYNC);
      q.push_back(e);
      if (q.size() > 2) begin
        g = q.pop_front();
        n_total++;
        if (g.de !== vga_de || g.hs !== vga_hsync || g.vs !== vga_vsync ||
            (g.chk && g.rgb !== {vga_r, vga_g, vga_b})) begin
          if (n_print < 30)
            $display("FAIL scoreboard_pixel t=%0t got rgb=%h hs=%b vs=%b de=%b want rgb=%h hs=%b vs=%b de=%b",
                     $time, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, vga_de,
                     g.rgb, g.hs, g.vs, g.de);
          n_print++;
        end else begin
          n_pass++;
        end
        n_total++;
        if ({frame_start, front_buf, swap_pending} !== {mfs, mfront, mpend}) begin
          if (n_print < 30)
            $display("FAIL scoreboard_ctrl t=%0t got fs/front/pend=%b%b%b want %b%b%b",
                     $time, frame_start, front_buf, swap_pending, mfs, mfront, mpend);
          n_print++;
        end else begin
          n_pass++;
        end
      end
    end
  end

  function automatic logic [11:0] pat0(input int a);
    return 12'(a * 57 + 1024);
  endfunction

  function automatic logic [11:0] pat1(input int a);
    return 12'(a * 123 + 7);
  endfunction

  task automatic wr(input int a, input logic [11:0] d);
    @(posedge clk); #2;
    we = 1'b1;
    write_addr = 6'(a);
    write_data = d;
  endtask

  task automatic idle();
    @(posedge clk); #2;
    we = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic pulse_swap();
    @(posedge clk); #2;
    swap_req = 1'b1;
    @(posedge clk); #2;
    swap_req = 1'b0;
  endtask

  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(posedge clk); #2;
      if (mh == h && mv == v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL wait_pos(%0d,%0d) timed out", h, v);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL wait_frame_start timed out");
    end
  endtask

  task automatic wait_front(input bit f0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (front_buf !== f0) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok) $display("FAIL wait_front_toggle got %b want %b", front_buf, ~f0);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({vga_r, vga_g, vga_b, vga_de} !== 13'h0)
      $display("FAIL reset_rgb_de got %h/%b want 000/0", {vga_r, vga_g, vga_b}, vga_de);
    else n_pass++;
    n_total++;
    if ({vga_hsync, vga_vsync} !== 2'b11)
      $display("FAIL reset_sync got %b%b want 11", vga_hsync, vga_vsync);
    else n_pass++;
    n_total++;
    if ({front_buf, swap_pending, frame_start} !== 3'b000)
      $display("FAIL reset_ctrl got %b%b%b want 000", front_buf, swap_pending, frame_start);
    else n_pass++;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({vga_de, vga_hsync, frame_start} !== 3'b010)
      $display("FAIL post_reset_c0 got de/hs/fs=%b%b%b want 010", vga_de, vga_hsync, frame_start);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({vga_de, frame_start, vga_r, vga_g, vga_b} !== {2'b01, 12'h000})
      $display("FAIL post_reset_c1 got de/fs=%b%b rgb=%h want 01/000", vga_de, frame_start, {vga_r, vga_g, vga_b});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({vga_de, frame_start} !== 2'b10)
      $display("FAIL post_reset_c2 got de/fs=%b%b want 10", vga_de, frame_start);
    else n_pass++;
  endtask

  task automatic fill_banks();
    bit ok;
    for (int a = 0; a < FB_PIXELS; a++) wr(a, pat1(a));
    idle();
    pulse_swap();
    wait_front(1'b0, ok);
    for (int a = 0; a < FB_PIXELS; a++) wr(a, pat0(a));
    idle();
  endtask

  task automatic test_timing();
    bit ok;
    int n;
    wait_fs(ok);
    n = 0;
    for (int i = 0; i < 100 && vga_hsync !== 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== H_VISIBLE + H_FRONT + 1)
      $display("FAIL hsync_offset got %0d want %0d", n, H_VISIBLE + H_FRONT + 1);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 100 && vga_hsync === 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== H_SYNC) $display("FAIL hsync_width got %0d want %0d", n, H_SYNC);
    else n_pass++;
    for (int i = 0; i < 100 && vga_hsync !== 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== H_TOTAL) $display("FAIL line_period got %0d want %0d", n, H_TOTAL);
    else n_pass++;
    for (int i = 0; i < 2*FRAME && vga_vsync !== 1'b0; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 2*FRAME && vga_vsync === 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== V_SYNC * H_TOTAL)
      $display("FAIL vsync_width got %0d want %0d", n, V_SYNC * H_TOTAL);
    else n_pass++;
    wait_fs(ok);
    n = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      n++;
      if (frame_start === 1'b1) break;
    end
    n_total++;
    if (n !== FRAME) $display("FAIL frame_period got %0d want %0d", n, FRAME);
    else n_pass++;
  endtask

  task automatic test_swap_basic();
    bit ok;
    bit f0;
    logic [11:0] want;
    f0 = front_buf;
    wr(0, 12'hF00);
    wr(1, 12'h0F0);
    idle();
    pulse_swap();
    wait_front(f0, ok);
    wait_fs(ok);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k inside {[1:4], [25:28]}) begin
        want = (k inside {1, 2, 25, 26}) ? 12'hF00 : 12'h0F0;
        n_total++;
        if ({vga_r, vga_g, vga_b} !== want || vga_de !== 1'b1)
          $display("FAIL swap_pixel k=%0d got %h de=%b want %h de=1", k, {vga_r, vga_g, vga_b}, vga_de, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_swap_merge();
    bit ok;
    bit f0;
    bit seen;
    int th;
    int tv;
    wait_pos(0, 2, ok);
    f0 = front_buf;
    swap_req = 1'b1;
    @(posedge clk); #2;
    swap_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (swap_pending !== 1'b1) $display("FAIL merge_pending1 got %b want 1", swap_pending);
    else n_pass++;
    wait_pos(0, 5, ok);
    swap_req = 1'b1;
    @(posedge clk); #2;
    swap_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({swap_pending, front_buf} !== {1'b1, f0})
      $display("FAIL merge_pending2 got pend/front=%b%b want 1%b", swap_pending, front_buf, f0);
    else n_pass++;
    seen = 1'b0;
    th = -1;
    tv = -1;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(posedge clk); #2;
      if (front_buf !== f0) begin
        seen = 1'b1;
        th = mh;
        tv = mv;
        break;
      end
    end
    n_total++;
    if (!seen || th != 0 || tv != V_VISIBLE)
      $display("FAIL merge_toggle_pos got seen=%b (%0d,%0d) want (0,%0d)", seen, th, tv, V_VISIBLE);
    else n_pass++;
    n_total++;
    if (swap_pending !== 1'b0) $display("FAIL merge_pending_clear got %b want 0", swap_pending);
    else n_pass++;
    repeat (FRAME) @(posedge clk);
    #2;
    n_total++;
    if (front_buf !== ~f0) $display("FAIL merge_single_toggle got %b want %b", front_buf, ~f0);
    else n_pass++;
  endtask

  task automatic test_swap_at_point();
    bit ok;
    bit f0;
    wait_pos(H_TOTAL-1, V_VISIBLE-1, ok);
    f0 = front_buf;
    swap_req = 1'b1;
    @(negedge clk);
    n_total++;
    if (swap_pending !== 1'b0) $display("FAIL point_pending_pre got %b want 0", swap_pending);
    else n_pass++;
    @(posedge clk); #2;
    swap_req = 1'b0;
    n_total++;
    if ({front_buf, swap_pending} !== {~f0, 1'b0})
      $display("FAIL point_toggle got front/pend=%b%b want %b0", front_buf, swap_pending, ~f0);
    else n_pass++;
  endtask

  task automatic test_write_oob();
    bit ok;
    bit f0;
    wr(0, 12'hA5A);
    wr(31, 12'h3C3);
    wr(32, 12'hFFF);
    wr(63, 12'hEEE);
    wr(33, 12'h111);
    idle();
    f0 = front_buf;
    pulse_swap();
    wait_front(f0, ok);
    wait_fs(ok);
    for (int k = 1; k <= 159; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if ({vga_r, vga_g, vga_b} !== 12'hA5A || vga_de !== 1'b1)
          $display("FAIL oob_addr0 got %h de=%b want a5a de=1", {vga_r, vga_g, vga_b}, vga_de);
        else n_pass++;
      end
      if (k == 159) begin
        n_total++;
        if ({vga_r, vga_g, vga_b} !== 12'h3C3 || vga_de !== 1'b1)
          $display("FAIL oob_addr31 got %h de=%b want 3c3 de=1", {vga_r, vga_g, vga_b}, vga_de);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    wait_pos(12, 5, ok);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({vga_r, vga_g, vga_b, vga_de, vga_hsync, vga_vsync, front_buf, swap_pending, frame_start}
          !== {12'h000, 1'b0, 2'b11, 3'b000})
        $display("FAIL midreset_hold c%0d got rgb=%h de=%b hs=%b vs=%b front=%b pend=%b fs=%b",
                 i, {vga_r, vga_g, vga_b}, vga_de, vga_hsync, vga_vsync, front_buf, swap_pending, frame_start);
      else n_pass++;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL midreset_fs_c0 got %b want 0", frame_start);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL midreset_fs_c1 got %b want 1", frame_start);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 100 && vga_hsync !== 1'b0; i++) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== H_VISIBLE + H_FRONT + 1)
      $display("FAIL midreset_hsync_offset got %0d want %0d", n, H_VISIBLE + H_FRONT + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    fill_banks();
    test_timing();
    test_swap_basic();
    test_swap_merge();
    test_swap_at_point();
    test_write_oob();
    test_reset_mid();
    repeat (FRAME + 10) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
